// File: rtl/dma_pkg.sv
// Shared DMA constants and controller state encoding, also used by the memory block.
// Ports: none (package).
// Latency/backpressure: n/a.
package dma_pkg;

  localparam int DATA_W  = 32;   // memory word width
  localparam int ADDR_W  = 8;    // memory word address width
  localparam int MEM_TOP = 191;  // reserved status word, never touched by a copy

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    RWAIT,
    WR,
    DONE,
    ERR
  } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Request latch, source/destination address counters, word counter and range check.
// Ports: load/init/step strobes from the FSM; src/dst/len request in; current addresses,
//        len_zero, range_err and last_word out. Results are registered one edge after each strobe.
module dma_addr_gen #(
  parameter int ADDR_W  = dma_pkg::ADDR_W,
  parameter int MEM_TOP = dma_pkg::MEM_TOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,       // accepting edge: latch the request
  input  logic              init,       // CHECK: point at the first word to move
  input  logic              step,       // WR: advance to the next word
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              len_zero,
  output logic              range_err,
  output logic              last_word
);

  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LIMIT   = (ADDR_W+1)'(MEM_TOP - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              desc_q, desc_d;

  // Last-word addresses carry one extra bit so a wrap past the top is seen as out of range.
  logic [ADDR_W:0] src_end;
  logic [ADDR_W:0] dst_end;
  logic            desc;

  always_comb begin
    src_end = {1'b0, src_base_q} + {1'b0, len_q} - ONE_W;
    dst_end = {1'b0, dst_base_q} + {1'b0, len_q} - ONE_W;
    // Destination starts inside the source window above src: copy top-down so
    // no source word is overwritten before it has been read.
    desc    = (src_base_q < dst_base_q) && ({1'b0, dst_base_q} <= src_end);

    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    len_d      = len_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    cnt_d      = cnt_q;
    desc_d     = desc_q;

    if (load) begin
      src_base_d = src;
      dst_base_d = dst;
      len_d      = len;
    end

    if (init) begin
      desc_d    = desc;
      cnt_d     = len_q;
      src_ptr_d = desc ? src_end[ADDR_W-1:0] : src_base_q;
      dst_ptr_d = desc ? dst_end[ADDR_W-1:0] : dst_base_q;
    end else if (step) begin
      cnt_d = cnt_q - ONE;
      if (desc_q) begin
        src_ptr_d = src_ptr_q - ONE;
        dst_ptr_d = dst_ptr_q - ONE;
      end else begin
        src_ptr_d = src_ptr_q + ONE;
        dst_ptr_d = dst_ptr_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      cnt_q      <= '0;
      desc_q     <= 1'b0;
    end else begin
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      len_q      <= len_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      cnt_q      <= cnt_d;
      desc_q     <= desc_d;
    end
  end

  assign src_addr  = src_ptr_q;
  assign dst_addr  = dst_ptr_q;
  assign len_zero  = (len_q == '0);
  assign range_err = !len_zero && ((src_end > LIMIT) || (dst_end > LIMIT));
  assign last_word = (cnt_q == ONE);

endmodule

// File: rtl/dma_ctrl.sv
// Word-copy DMA: moves len words src->dst over a shared tri-state bus, overlap-safe.
// Ports: clk, rst_n (sync, active-low), start/src/dst/len request; busy/done/err status;
//        index (chip select + word address), memWR, databus (driven only while writing).
// Latency: 3 cycles per word; done 3*len+2 cycles after acceptance, err 2 cycles after.
module dma_ctrl #(
  parameter int DATA_W  = dma_pkg::DATA_W,
  parameter int ADDR_W  = dma_pkg::ADDR_W,
  parameter int MEM_TOP = dma_pkg::MEM_TOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   index,
  output logic              memWR,
  inout  wire  [DATA_W-1:0] databus
);

  import dma_pkg::*;

  dma_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              load;
  logic              init;
  logic              step;
  logic              drive;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              len_zero;
  logic              range_err;
  logic              last_word;

  dma_addr_gen #(
    .ADDR_W  (ADDR_W),
    .MEM_TOP (MEM_TOP)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .init      (init),
    .step      (step),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_zero  (len_zero),
    .range_err (range_err),
    .last_word (last_word)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    load    = 1'b0;
    init    = 1'b0;
    step    = 1'b0;
    drive   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    index   = '0;
    memWR   = 1'b0;
    busy    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        init = 1'b1;
        if (range_err)     state_d = ERR;
        else if (len_zero) state_d = DONE;
        else               state_d = RD;
      end
      RD: begin
        index   = {1'b1, src_addr};
        state_d = RWAIT;
      end
      RWAIT: begin
        // Memory has had a full cycle to respond; capture on the way out.
        index   = {1'b1, src_addr};
        data_d  = databus;
        state_d = WR;
      end
      WR: begin
        index   = {1'b1, dst_addr};
        memWR   = 1'b1;
        drive   = 1'b1;
        step    = 1'b1;
        state_d = last_word ? DONE : RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign databus = drive ? data_q : {DATA_W{1'bz}};

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 32, memory word width.
REQ-002 SHALL have parameter ADDR_W, 8, memory word address width.
REQ-003 SHALL have parameter MEM_TOP, 191, reserved status word address; transfers never touch it.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  in  1  transfer request, sampled only in IDLE.
REQ-007 SHALL have port src  in  ADDR_W  first source word address.
REQ-008 SHALL have port dst  in  ADDR_W  first destination word address.
REQ-009 SHALL have port len  in  ADDR_W  word count.
REQ-010 SHALL have port busy  out  1  high from the accepting edge until DONE/ERR exits.
REQ-011 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port err  out  1  one-cycle pulse on a rejected request.
REQ-013 SHALL have port index  out  ADDR_W+1  bit[8]=memory chip select, bits[7:0]=word address.
REQ-014 SHALL have port memWR  out  1  1=write, 0=read.
REQ-015 SHALL have port databus  inout  DATA_W  shared bus, driven only in WR, else high-Z.

Function
REQ-016 SHALL implement states IDLE, CHECK, RD, RWAIT, WR, DONE, ERR.
REQ-017 SHALL move IDLE->CHECK on start=1, latching src, dst, len; busy rises on that edge.
REQ-018 SHALL, in CHECK, compute src+len-1 and dst+len-1 at 9 bits and go to ERR if len!=0 and either end exceeds MEM_TOP-1 (190).
REQ-019 SHALL, in CHECK, go to DONE if len=0, with no chip-select activity.
REQ-020 SHALL, otherwise, copy descending (last word first) when src<dst and dst<=src+len-1, else ascending.
REQ-021 SHALL, per word: RD drives index={1,src_i}, memWR=0; RWAIT holds both; the edge leaving RWAIT captures databus; WR drives index={1,dst_i}, memWR=1, databus=captured word. Cost is exactly 3 cycles per word.
REQ-022 SHALL go from WR to RD while words remain, else to DONE; word counter is ADDR_W wide and decrements in WR.
REQ-023 SHALL assert done in DONE and err in ERR for one cycle, clear busy on the next edge, and return to IDLE.
REQ-024 SHALL place done exactly 3*len+2 cycles after the accepting edge; err exactly 2 cycles after.
REQ-025 SHALL ignore start while busy=1 and while in DONE/ERR.
REQ-026 SHALL drive index[8]=0 and memWR=0 outside RD/RWAIT/WR.
REQ-027 SHALL never address MEM_TOP; src=dst is legal and rewrites the same data.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge, enter IDLE with busy=0, done=0, err=0, index=0, memWR=0, databus high-Z, and counters and latches cleared.
REQ-029 SHALL honour reset mid-transfer: any write already issued stands, and no further bus cycle follows.

Structure
REQ-030 SHALL take DATA_W, ADDR_W, MEM_TOP and the state enumeration from shared package dma_pkg, reused by the memory block.
REQ-031 SHALL use one sub-module, dma_addr_gen: the start/len latch, the up/down address counters and the range check.

Verification
REQ-032 SHALL test memory words 0..4 = 1..5, start with src=0, dst=10, len=5: words 10..14 become 1..5, done at cycle 17, busy low at 18.
REQ-033 SHALL test len=0: done at cycle 2, index[8] stays 0, memory unchanged.
REQ-034 SHALL test overlapping src=0, dst=2, len=5: words 2..6 become 1..5, with the descending address order on index checked.
REQ-035 SHALL test dst=188, len=5: err at cycle 2, no write, word 191 unchanged.
REQ-036 SHALL test rst_n=0 after the second WR of the REQ-032 copy: only words 10 and 11 are written, busy=0, and databus is high-Z on the next cycle.
REQ-037 SHALL test a second start pulse during a transfer: it is ignored, and only the first transfer's done fires.
